// File: rtl/dsa_pkg.sv
// dsa_pkg: shared FSM state type and counter-width helper for the digit-serial adder.
package dsa_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   function automatic int cnt_width(input int width, input int digit);
      return (width / digit > 1) ? $clog2(width / digit) : 1;
   endfunction
endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple adder built from full-adder cells.
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb_in
);
   logic [DIGIT:0] c;
   assign c[0] = ci;
   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end
   assign co       = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle adder, DIGIT bits per clock with a registered inter-digit carry.
// Optional signed-overflow output enabled by defining DSA_OVERFLOW_EN.
module digit_serial_adder
   import dsa_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef DSA_OVERFLOW_EN
   output logic             ovf,
`endif
   output logic             cout
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = cnt_width(WIDTH, DIGIT);

   if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_cfg
      $error("digit_serial_adder: DIGIT must be >=1 and divide WIDTH");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, cout_q, cout_d;
   logic [DIGIT-1:0] x, y, s;
   logic             co, c_msb;

   digit_adder #(.DIGIT(DIGIT)) u_dig (
      .x       (x),
      .y       (y),
      .ci      (carry_q),
      .s       (s),
      .co      (co),
      .c_msb_in(c_msb)
   );

`ifdef DSA_OVERFLOW_EN
   logic ovf_q, ovf_d;
   always_comb begin
      ovf_d = ovf_q;
      if (state_q == BUSY && cnt_q == CW'(NDIG - 1)) ovf_d = c_msb ^ co;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`else
   logic unused_c_msb;
   assign unused_c_msb = c_msb;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      x       = '0;
      y       = '0;
      // operand digit mux driven by the digit counter
      for (int i = 0; i < NDIG; i++) begin
         if (cnt_q == CW'(i)) begin
            x = a_q[i*DIGIT +: DIGIT];
            y = b_q[i*DIGIT +: DIGIT];
         end
      end
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            for (int i = 0; i < NDIG; i++) begin
               if (cnt_q == CW'(i)) sum_d[i*DIGIT +: DIGIT] = s;
            end
            carry_d = co;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(NDIG - 1)) begin
               cout_d  = co;
               state_d = DONE;
            end
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed scoreboard bench for WIDTH=8 with DIGIT=2 and DIGIT=8 instances.
module tb_digit_serial_adder;
   typedef struct packed {
      logic [7:0] s;
      logic       c;
      logic       v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       iv2 = 1'b0, ir2, ov2, or2 = 1'b0, cin2 = 1'b0, cout2;
   logic [7:0] a2 = '0, b2 = '0, sum2;
   logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, cin8 = 1'b0, cout8;
   logic [7:0] a8 = '0, b8 = '0, sum8;
`ifdef DSA_OVERFLOW_EN
   logic       ovf2, ovf8;
`endif
   exp_t       q[$];
   exp_t       e;
   int         checks = 0;
   int         errors = 0;
   int         lat;

   always #5 clk = ~clk;

   digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv2),
      .in_ready (ir2),
      .a        (a2),
      .b        (b2),
      .cin      (cin2),
      .out_valid(ov2),
      .out_ready(or2),
      .sum      (sum2),
`ifdef DSA_OVERFLOW_EN
      .ovf      (ovf2),
`endif
      .cout     (cout2)
   );

   digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv8),
      .in_ready (ir8),
      .a        (a8),
      .b        (b8),
      .cin      (cin8),
      .out_valid(ov8),
      .out_ready(or8),
      .sum      (sum8),
`ifdef DSA_OVERFLOW_EN
      .ovf      (ovf8),
`endif
      .cout     (cout8)
   );

   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic ci);
      logic [8:0] t;
      t = {1'b0, x} + {1'b0, y} + {8'd0, ci};
      model.s = t[7:0];
      model.c = t[8];
      model.v = (x[7] == y[7]) && (t[7] != x[7]);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic ci);
      @(negedge clk);
      for (int k = 0; k < 20 && !ir2; k++) @(negedge clk);
      check("in_ready_before_accept", 32'(ir2), 32'd1);
      iv2  = 1'b1;
      a2   = x;
      b2   = y;
      cin2 = ci;
      q.push_back(model(x, y, ci));
      @(posedge clk);
      @(negedge clk);
      iv2  = 1'b0;
      a2   = ~x;
      b2   = ~y;
      cin2 = ~ci;
   endtask

   task automatic wait_done();
      lat = 0;
      while (!ov2 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'd4);
   endtask

   task automatic finish_op(input string tag);
      check({tag, "_out_valid"}, 32'(ov2), 32'd1);
      if (q.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 32'(q.size()), 32'd1);
      end else begin
         e = q.pop_front();
         check({tag, "_sum"}, 32'(sum2), 32'(e.s));
         check({tag, "_cout"}, 32'(cout2), 32'(e.c));
`ifdef DSA_OVERFLOW_EN
         check({tag, "_ovf"}, 32'(ovf2), 32'(e.v));
`endif
      end
      or2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or2 = 1'b0;
      check({tag, "_in_ready_after"}, 32'(ir2), 32'd1);
      check({tag, "_out_valid_after"}, 32'(ov2), 32'd0);
   endtask

   initial begin
      #1;
      check("rst_in_ready", 32'(ir2), 32'd1);
      check("rst_out_valid", 32'(ov2), 32'd0);
      check("rst_sum", 32'(sum2), 32'd0);
      check("rst_cout", 32'(cout2), 32'd0);
`ifdef DSA_OVERFLOW_EN
      check("rst_ovf", 32'(ovf2), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      start_op(8'h3C, 8'h05, 1'b0); wait_done(); finish_op("basic");
      start_op(8'hFF, 8'h01, 1'b0); wait_done(); finish_op("wrap");
      start_op(8'hFF, 8'hFF, 1'b1); wait_done(); finish_op("all_ones_cin");
      start_op(8'h7F, 8'h01, 1'b0); wait_done(); finish_op("ovf_pos");
      start_op(8'h80, 8'h80, 1'b0); wait_done(); finish_op("ovf_neg");
      start_op(8'h5A, 8'hC3, 1'b1); wait_done(); finish_op("mixed");

      // backpressure: result must hold while new operands are offered
      start_op(8'h12, 8'h34, 1'b0);
      wait_done();
      iv2 = 1'b1;
      a2  = 8'hAA;
      b2  = 8'hAA;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(ir2), 32'd0);
         check("bp_out_valid", 32'(ov2), 32'd1);
         check("bp_sum", 32'(sum2), 32'(model(8'h12, 8'h34, 1'b0).s));
         check("bp_cout", 32'(cout2), 32'd0);
      end
      iv2 = 1'b0;
      finish_op("bp");

      // reset during the second BUSY cycle aborts the operation
      start_op(8'hF0, 8'h0F, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(ov2), 32'd0);
      check("mid_rst_in_ready", 32'(ir2), 32'd1);
      check("mid_rst_sum", 32'(sum2), 32'd0);
      void'(q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("mid_rst_no_result", 32'(ov2), 32'd0);
      start_op(8'h21, 8'h43, 1'b0); wait_done(); finish_op("after_rst");

      // single-digit configuration
      @(negedge clk);
      check("d8_in_ready", 32'(ir8), 32'd1);
      iv8 = 1'b1;
      a8  = 8'h10;
      b8  = 8'h20;
      @(posedge clk);
      @(negedge clk);
      iv8 = 1'b0;
      a8  = 8'hFF;
      lat = 0;
      while (!ov8 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("d8_latency", 32'(lat), 32'd1);
      check("d8_sum", 32'(sum8), 32'h30);
      check("d8_cout", 32'(cout8), 32'd0);
`ifdef DSA_OVERFLOW_EN
      check("d8_ovf", 32'(ovf8), 32'd0);
`endif
      or8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or8 = 1'b0;
      check("d8_in_ready_after", 32'(ir8), 32'd1);

      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
